// File: rtl/mux_select_elastic.sv
// Elastic N-way select: a select token forwards one data channel's token into a
// 2-entry output buffer, so a stalled consumer never stalls the inputs combinationally.
module mux_select_elastic #(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 32,
    parameter int unsigned SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SELW-1:0]   sel_i,
    input  logic              sel_valid_i,
    output logic              sel_ready_o,
    input  logic [N*W-1:0]    data_i,
    input  logic [N-1:0]      data_valid_i,
    output logic [N-1:0]      data_ready_o,
    output logic [W-1:0]      out_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              err_o
);

    localparam int unsigned NP = 1 << SELW;
    // One bit per encodable select value; set for values that name a real channel.
    localparam logic [NP-1:0] RANGE_MASK = {NP{1'b1}} >> (NP - N);

    logic [W-1:0]  mem [2];
    logic          head;
    logic [1:0]    count;
    logic          err;

    logic          space;
    logic          inrange;
    logic          fire;
    logic          drop;
    logic          pop;
    logic          tail;
    logic [NP-1:0] dv_ext;
    logic [W-1:0]  sel_data;

    // Select decode and handshakes; space comes from registered count only.
    always_comb begin
        dv_ext   = NP'(data_valid_i);
        space    = (count < 2'd2);
        inrange  = RANGE_MASK[sel_i];
        fire     = !reset && sel_valid_i && inrange && dv_ext[sel_i] && space;
        drop     = !reset && sel_valid_i && !inrange && space;
        sel_ready_o = fire || drop;
        data_ready_o = '0;
        sel_data     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            data_ready_o[k] = fire && (sel_i == SELW'(k));
            if (sel_i == SELW'(k)) begin
                sel_data = data_i[k*W +: W];
            end
        end
    end

    // Buffer head view and tail slot selection.
    always_comb begin
        out_valid_o = (count != 2'd0);
        out_o       = out_valid_o ? mem[head] : '0;
        pop         = out_valid_o && out_ready_i;
        tail        = count[0] ? ~head : head;
        err_o       = err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            head  <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (pop) begin
                head <= ~head;
            end
            count <= count + 2'(fire) - 2'(pop);
            if (drop) begin
                err <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (fire) begin
            mem[tail] <= sel_data;
        end
    end

endmodule

// File: tb/tb_mux_select_elastic.sv
// Bench for mux_select_elastic: directed vector table, hand sequences for
// throughput / out-of-range / reset, and random traffic against a queue model.
module tb_mux_select_elastic;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance
    logic         reset;
    logic [1:0]   sel;
    logic         sv;
    logic         sr;
    logic [127:0] data;
    logic [3:0]   dv;
    logic [3:0]   dr;
    logic [31:0]  out;
    logic         ov;
    logic         ordy;
    logic         err;

    // N=3 instance
    logic         reset3;
    logic [1:0]   sel3;
    logic         sv3;
    logic         sr3;
    logic [95:0]  data3;
    logic [2:0]   dv3;
    logic [2:0]   dr3;
    logic [31:0]  out3;
    logic         ov3;
    logic         ordy3;
    logic         err3;

    mux_select_elastic #(.N(4), .W(32)) dut4 (
        .clk(clk), .reset(reset), .sel_i(sel), .sel_valid_i(sv), .sel_ready_o(sr),
        .data_i(data), .data_valid_i(dv), .data_ready_o(dr),
        .out_o(out), .out_valid_o(ov), .out_ready_i(ordy), .err_o(err)
    );

    mux_select_elastic #(.N(3), .W(32)) dut3 (
        .clk(clk), .reset(reset3), .sel_i(sel3), .sel_valid_i(sv3), .sel_ready_o(sr3),
        .data_i(data3), .data_valid_i(dv3), .data_ready_o(dr3),
        .out_o(out3), .out_valid_o(ov3), .out_ready_i(ordy3), .err_o(err3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] pat4(input logic [31:0] base);
        logic [127:0] p;
        for (int k = 0; k < 4; k++) p[k*32 +: 32] = base + 32'(k);
        return p;
    endfunction

    function automatic logic [95:0] pat3(input logic [31:0] base);
        logic [95:0] p;
        for (int k = 0; k < 3; k++) p[k*32 +: 32] = base + 32'(k);
        return p;
    endfunction

    typedef struct {
        logic        rst;
        logic [1:0]  sel;
        logic        sv;
        logic [3:0]  dv;
        logic        ordy;
        logic [31:0] base;
        logic        exp_sr;
        logic [3:0]  exp_dr;
        logic        exp_ov;
        logic [31:0] exp_out;
    } vec_t;

    vec_t tbl[16];
    logic [31:0] q[$];

    initial begin
        // Basic select, missing-data stall, backpressure/full.
        tbl[0]  = '{1'b1, 2'd2, 1'b1, 4'hF, 1'b1, 32'hCAFE0000, 1'b0, 4'b0000, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 2'd2, 1'b1, 4'hF, 1'b1, 32'hCAFE0000, 1'b1, 4'b0100, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 4'hF, 1'b1, 32'hCAFE0000, 1'b0, 4'b0000, 1'b1, 32'hCAFE0002};
        tbl[3]  = '{1'b0, 2'd1, 1'b1, 4'hD, 1'b1, 32'hCAFE0000, 1'b0, 4'b0000, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 2'd1, 1'b1, 4'hD, 1'b1, 32'hCAFE0000, 1'b0, 4'b0000, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 2'd1, 1'b1, 4'hD, 1'b1, 32'hCAFE0000, 1'b0, 4'b0000, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 2'd1, 1'b1, 4'hF, 1'b1, 32'hCAFE0000, 1'b1, 4'b0010, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 2'd1, 1'b0, 4'hF, 1'b1, 32'hCAFE0000, 1'b0, 4'b0000, 1'b1, 32'hCAFE0001};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 4'hF, 1'b0, 32'd10,       1'b1, 4'b0001, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 2'd1, 1'b1, 4'hF, 1'b0, 32'd10,       1'b1, 4'b0010, 1'b1, 32'd10};
        tbl[10] = '{1'b0, 2'd2, 1'b1, 4'hF, 1'b0, 32'd10,       1'b0, 4'b0000, 1'b1, 32'd10};
        tbl[11] = '{1'b0, 2'd2, 1'b1, 4'hF, 1'b0, 32'd10,       1'b0, 4'b0000, 1'b1, 32'd10};
        tbl[12] = '{1'b0, 2'd2, 1'b1, 4'hF, 1'b1, 32'd10,       1'b0, 4'b0000, 1'b1, 32'd10};
        tbl[13] = '{1'b0, 2'd2, 1'b1, 4'hF, 1'b1, 32'd10,       1'b1, 4'b0100, 1'b1, 32'd11};
        tbl[14] = '{1'b0, 2'd0, 1'b0, 4'hF, 1'b1, 32'd10,       1'b0, 4'b0000, 1'b1, 32'd12};
        tbl[15] = '{1'b0, 2'd0, 1'b0, 4'hF, 1'b1, 32'd10,       1'b0, 4'b0000, 1'b0, 32'h0};

        reset = 1'b1; sel = '0; sv = 1'b0; data = '0; dv = '0; ordy = 1'b0;
        reset3 = 1'b1; sel3 = '0; sv3 = 1'b0; data3 = '0; dv3 = '0; ordy3 = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            reset = tbl[i].rst; sel = tbl[i].sel; sv = tbl[i].sv; dv = tbl[i].dv;
            ordy = tbl[i].ordy; data = pat4(tbl[i].base);
            #1;
            check($sformatf("tbl%0d sel_ready", i), 64'(sr), 64'(tbl[i].exp_sr));
            check($sformatf("tbl%0d data_ready", i), 64'(dr), 64'(tbl[i].exp_dr));
            check($sformatf("tbl%0d out_valid", i), 64'(ov), 64'(tbl[i].exp_ov));
            check($sformatf("tbl%0d out", i), 64'(out), 64'(tbl[i].exp_out));
            @(negedge clk);
        end

        // Full throughput: one token per cycle in select order.
        ordy = 1'b1; dv = 4'hF;
        for (int i = 0; i < 10; i++) begin
            sv = (i < 8); sel = 2'(i % 4); data = pat4(32'h1000 * (i + 1));
            #1;
            check($sformatf("thr%0d sel_ready", i), 64'(sr), 64'(i < 8));
            check($sformatf("thr%0d out_valid", i), 64'(ov), 64'(i >= 1 && i <= 8));
            if (i >= 1 && i <= 8)
                check($sformatf("thr%0d out", i), 64'(out), 64'(32'h1000 * i + 32'((i - 1) % 4)));
            @(negedge clk);
        end
        sv = 1'b0;

        // Out-of-range select on N=3, then reset mid-operation.
        reset3 = 1'b0; data3 = pat3(32'hD000); dv3 = 3'b111; ordy3 = 1'b1;
        sel3 = 2'd3; sv3 = 1'b1; #1;
        check("oor sel_ready", 64'(sr3), 64'd1);
        check("oor data_ready", 64'(dr3), 64'd0);
        check("oor err_before", 64'(err3), 64'd0);
        @(negedge clk);
        sel3 = 2'd0; #1;
        check("oor err_set", 64'(err3), 64'd1);
        check("oor no_output", 64'(ov3), 64'd0);
        check("after_oor data_ready", 64'(dr3), 64'b001);
        @(negedge clk);
        sv3 = 1'b0; #1;
        check("after_oor out_valid", 64'(ov3), 64'd1);
        check("after_oor out", 64'(out3), 64'hD000);
        check("err_sticky", 64'(err3), 64'd1);
        @(negedge clk);
        ordy3 = 1'b0; sv3 = 1'b1; sel3 = 2'd0; #1;
        check("fill0 sel_ready", 64'(sr3), 64'd1);
        @(negedge clk);
        sel3 = 2'd1; #1;
        check("fill1 sel_ready", 64'(sr3), 64'd1);
        @(negedge clk);
        sel3 = 2'd2; reset3 = 1'b1; #1;
        check("rst sel_ready", 64'(sr3), 64'd0);
        check("rst data_ready", 64'(dr3), 64'd0);
        check("prerst out_valid", 64'(ov3), 64'd1);
        check("prerst err", 64'(err3), 64'd1);
        @(negedge clk);
        reset3 = 1'b0; sv3 = 1'b0; ordy3 = 1'b1; #1;
        check("postrst out_valid", 64'(ov3), 64'd0);
        check("postrst out", 64'(out3), 64'd0);
        check("postrst err", 64'(err3), 64'd0);
        @(negedge clk);
        sv3 = 1'b1; sel3 = 2'd1; #1;
        check("resume sel_ready", 64'(sr3), 64'd1);
        check("resume data_ready", 64'(dr3), 64'b010);
        @(negedge clk);
        sv3 = 1'b0; #1;
        check("resume out_valid", 64'(ov3), 64'd1);
        check("resume out", 64'(out3), 64'hD001);
        @(negedge clk);

        // Random traffic against a FIFO model; the dut is empty here.
        q.delete();
        for (int c = 0; c < 400; c++) begin
            logic        m_fire;
            logic        m_ov;
            logic [31:0] m_out;
            logic [31:0] word;
            sv = ($urandom_range(3) != 0); sel = 2'($urandom_range(3));
            dv = 4'($urandom); ordy = ($urandom_range(3) != 0);
            for (int k = 0; k < 4; k++) data[k*32 +: 32] = $urandom;
            word   = data[32*int'(sel) +: 32];
            m_fire = sv && dv[sel] && (q.size() < 2);
            m_ov   = (q.size() != 0);
            m_out  = m_ov ? q[0] : 32'h0;
            #1;
            check("rnd sel_ready", 64'(sr), 64'(m_fire));
            check("rnd data_ready", 64'(dr), m_fire ? (64'd1 << sel) : 64'd0);
            check("rnd out_valid", 64'(ov), 64'(m_ov));
            check("rnd out", 64'(out), 64'(m_out));
            if (m_ov && ordy) void'(q.pop_front());
            if (m_fire) q.push_back(word);
            @(negedge clk);
        end
        check("n4 err stays clear", 64'(err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule

// File: doc/mux_select_elastic.md
Name: mux_select_elastic

Overview:
- Parametrised, registered N-way, W-bit select operator for the RipTide dataflow fabric.
- Generalises the single-bit 2:1 select into a token-based, elastic mux. A select token picks one of N data channels, and that channel's token is forwarded to the output.
- A 2-entry output buffer decouples backpressure, so a stalled consumer does not stall the select network combinationally.

Parameters:
- N, 4, number of data input channels (N >= 2)
- W, 32, data width in bits
- SELW, $clog2(N), select width (derived; must satisfy 2**SELW >= N)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- sel_i  input  SELW  select token value
- sel_valid_i  input  1  select token present
- sel_ready_o  output  1  select token consumed this cycle
- data_i  input  N*W  packed data; channel k occupies bits [k*W +: W]
- data_valid_i  input  N  per-channel token present
- data_ready_o  output  N  per-channel token consumed this cycle
- out_o  output  W  output token data (head of buffer)
- out_valid_o  output  1  output token present
- out_ready_i  input  1  consumer accepts output token
- err_o  output  1  sticky flag: an out-of-range select was seen

Behaviour:
- Handshake: a transfer on any channel occurs on a rising edge where valid && ready are both high. Valid must not depend on ready.
- Internal state:
  - 2-entry FIFO buffer holding W-bit entries
  - count, range 0..2
  - err register
- Definitions:
  - space = (count < 2); registered only, with no dependence on out_ready_i
  - inrange = (sel_i < N)
  - fire = sel_valid_i && inrange && data_valid_i[sel_i] && space
  - drop = sel_valid_i && !inrange && space
- Ready outputs (combinational):
  - sel_ready_o = fire || drop
  - data_ready_o[k] = fire && (sel_i == k)
  - All other data_ready_o bits are 0, so non-selected channels keep their tokens.
- fire: data_i[sel_i*W +: W] is pushed into the buffer tail. The select token and the selected data token are consumed together.
- drop: the select token is consumed, no data is consumed, nothing is pushed, and err is set to 1 on that edge.
- Pop: out_valid_o && out_ready_i pops the head.
- Outputs from the buffer:
  - out_valid_o = (count != 0)
  - out_o = head entry, or 0 when empty
- Latency: a token accepted at edge t appears on out_o / out_valid_o after edge t; one cycle minimum.
- Throughput: with out_ready_i held high and inputs valid, the block sustains one token per cycle.
- Ordering: output order equals fire order (FIFO).
- Simultaneous push and pop:
  - count=1: count stays 1, and the new entry becomes head after the pop.
  - count=2: no push is possible because space=0; the pop brings count to 1.
- Full (count=2): sel_ready_o=0 and all data_ready_o=0 regardless of inputs. Input tokens are held.
- Empty: out_valid_o=0 and out_o=0.
- err_o: sticky, cleared only by reset. It has no effect on the data path beyond the dropped select token.
- Reset (synchronous, highest priority):
  - count=0, out_valid_o=0, out_o=0, err_o=0
  - sel_ready_o=0 and all data_ready_o=0 while reset is high
  - Reset mid-operation discards buffered tokens. No handshake completes on a reset edge.
- Unknown or X on sel_i while sel_valid_i=0 must not affect any ready output.

Test Plan:
- Basic select: N=4, W=32, reset 2 cycles, data_valid_i=4'b1111, data_i ch2=32'hCAFE0002, sel_i=2, sel_valid_i=1 for 1 cycle, out_ready_i=1 -> sel_ready_o=1 and data_ready_o=4'b0100 that cycle; next cycle out_valid_o=1, out_o=32'hCAFE0002; ch0/1/3 tokens not consumed.
- Missing data stall: sel_i=1, sel_valid_i=1, data_valid_i[1]=0 for 3 cycles, then 1 -> sel_ready_o=0 for 3 cycles; fires on the 4th cycle; out_o = ch1 value one cycle later.
- Backpressure/full: out_ready_i=0, fire sel 0,1,2 with values 10,11,12 on consecutive cycles -> the first two accepted; the third is held with sel_ready_o=0 (count=2); raise out_ready_i -> out_o sequence 10, 11, 12 in order, with 12 accepted the cycle after the first pop.
- Full throughput: out_ready_i=1, sel_i cycling 0,1,2,3 every cycle for 8 cycles with all data valid -> 8 outputs on 8 consecutive cycles, in select order.
- Out-of-range (N=3, SELW=2): sel_i=3, sel_valid_i=1 -> sel_ready_o=1, data_ready_o=0, no output token, err_o=1 next cycle and held; a following sel_i=0 still fires normally.
- Reset mid-operation: with count=2 and err_o=1, assert reset 1 cycle -> after the edge out_valid_o=0, out_o=0, err_o=0; no ready asserted during reset; normal operation resumes the cycle after reset deasserts.
